// File: rtl/axil_regbank.sv
// ============================================================================
//  Module : axil_regbank
//  AXI4-Lite slave bank of NUM_REGS 32-bit registers with byte-strobe writes,
//  pulse/read-only registers, and a W1C interrupt status/enable pair.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module axil_regbank #(
    parameter int                  AXIL_AW      = 8,
    parameter int                  NUM_REGS     = 32,
    parameter logic [NUM_REGS-1:0] PULSE_MASK   = {{(NUM_REGS-1){1'b0}}, 1'b1},
    parameter logic [NUM_REGS-1:0] RO_MASK      = '0,
    parameter int                  IRQ_W        = 8,
    parameter int                  IRQ_STAT_IDX = 30,
    parameter int                  IRQ_EN_IDX   = 31
) (
    input  logic                     aclk,
    input  logic                     arest,
    input  logic [AXIL_AW-1:0]       s_axil_awaddr,
    input  logic [2:0]               s_axil_awprot,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [31:0]              s_axil_wdata,
    input  logic [3:0]               s_axil_wstrb,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    input  logic [AXIL_AW-1:0]       s_axil_araddr,
    input  logic [2:0]               s_axil_arprot,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    output logic [32*NUM_REGS-1:0]   cfg_regs,
    output logic [NUM_REGS-1:0]      cfg_wr,
    input  logic [32*NUM_REGS-1:0]   sts_regs,
    input  logic [IRQ_W-1:0]         irq_src,
    output logic                     irq
);

    localparam logic [31:0] IRQ_MASK = (IRQ_W >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << IRQ_W) - 32'd1);

    logic [AXIL_AW-3:0]      aw_idx;
    logic                    aw_full;
    logic [31:0]             w_data;
    logic [3:0]              w_strb;
    logic                    w_full;
    logic [32*NUM_REGS-1:0]  regs_q;
    logic [32*NUM_REGS-1:0]  regs_nxt;
    logic [NUM_REGS-1:0]     hit;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic        aw_full_nxt, w_full_nxt, bvalid_nxt, rvalid_nxt;
    logic [31:0] wr_idx32, rd_idx32, wmask, wr_bits, irq_src32, rd_mux;
    logic        wr_in_range, rd_in_range;
    logic        unused;

    assign aw_hs  = s_axil_awvalid & s_axil_awready;
    assign w_hs   = s_axil_wvalid & s_axil_wready;
    assign ar_hs  = s_axil_arvalid & s_axil_arready;
    assign commit = aw_full & w_full;

    assign aw_full_nxt = commit ? 1'b0 : (aw_full | aw_hs);
    assign w_full_nxt  = commit ? 1'b0 : (w_full | w_hs);
    assign bvalid_nxt  = commit | (s_axil_bvalid & ~s_axil_bready);
    assign rvalid_nxt  = ar_hs | (s_axil_rvalid & ~s_axil_rready);

    assign wr_idx32    = 32'(aw_idx);
    assign rd_idx32    = 32'(s_axil_araddr[AXIL_AW-1:2]);
    assign wr_in_range = wr_idx32 < NUM_REGS;
    assign rd_in_range = rd_idx32 < NUM_REGS;
    assign wmask       = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
    assign wr_bits     = w_data & wmask;
    assign irq_src32   = 32'(irq_src);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        logic [31:0] cur;
        assign cur    = regs_q[32*i +: 32];
        assign hit[i] = commit & wr_in_range & (wr_idx32 == 32'(i)) & ~RO_MASK[i];

        if (i == IRQ_STAT_IDX) begin : g_stat
            // Source set is OR-ed after the clear so a live source wins.
            assign regs_nxt[32*i +: 32] =
                ((cur & ~(hit[i] ? wr_bits : 32'd0)) | irq_src32) & IRQ_MASK;
        end else if (RO_MASK[i]) begin : g_ro
            assign regs_nxt[32*i +: 32] = 32'd0;
        end else if (PULSE_MASK[i]) begin : g_pulse
            assign regs_nxt[32*i +: 32] = hit[i] ? wr_bits : 32'd0;
        end else if (i == IRQ_EN_IDX) begin : g_en
            assign regs_nxt[32*i +: 32] = hit[i] ? (((cur & ~wmask) | wr_bits) & IRQ_MASK) : cur;
        end else begin : g_rw
            assign regs_nxt[32*i +: 32] = hit[i] ? ((cur & ~wmask) | wr_bits) : cur;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx32 == 32'(i))
                rd_mux = RO_MASK[i] ? sts_regs[32*i +: 32] : regs_q[32*i +: 32];
        end
    end

    always_ff @(posedge aclk or posedge arest) begin
        if (arest) begin
            aw_idx         <= '0;
            aw_full        <= 1'b0;
            w_data         <= 32'd0;
            w_strb         <= 4'd0;
            w_full         <= 1'b0;
            regs_q         <= '0;
            cfg_wr         <= '0;
            irq            <= 1'b0;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= 2'b00;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rdata   <= 32'd0;
            s_axil_rresp   <= 2'b00;
        end else begin
            if (aw_hs) aw_idx <= s_axil_awaddr[AXIL_AW-1:2];
            if (w_hs) begin
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
            aw_full        <= aw_full_nxt;
            w_full         <= w_full_nxt;
            s_axil_bvalid  <= bvalid_nxt;
            s_axil_awready <= ~aw_full_nxt & ~bvalid_nxt;
            s_axil_wready  <= ~w_full_nxt & ~bvalid_nxt;
            if (commit) s_axil_bresp <= wr_in_range ? 2'b00 : 2'b10;

            regs_q <= regs_nxt;
            cfg_wr <= hit;
            irq    <= |(regs_q[32*IRQ_STAT_IDX +: 32] & regs_q[32*IRQ_EN_IDX +: 32]);

            s_axil_rvalid  <= rvalid_nxt;
            s_axil_arready <= ~rvalid_nxt;
            if (ar_hs) begin
                s_axil_rdata <= rd_in_range ? rd_mux : 32'd0;
                s_axil_rresp <= rd_in_range ? 2'b00 : 2'b10;
            end
        end
    end

    assign cfg_regs = regs_q;
    assign unused   = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0],
                        s_axil_araddr[1:0], sts_regs};

endmodule

`default_nettype wire

// File: tb/tb_axil_regbank.sv
// ============================================================================
//  Module : tb_axil_regbank
//  Self-checking bench for axil_regbank: vector table plus corner sequences.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axil_regbank;

    localparam int NREGS = 32;
    localparam int TMO   = 50;

    logic aclk  = 1'b0;
    logic arest = 1'b0;
    always #5 aclk = ~aclk;

    logic [7:0]          awaddr = '0, araddr = '0;
    logic [2:0]          awprot = '0, arprot = '0;
    logic                awvalid = 0, wvalid = 0, arvalid = 0;
    logic                bready = 1, rready = 1;
    logic [31:0]         wdata = '0;
    logic [3:0]          wstrb = '0;
    logic                awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]          bresp, rresp;
    logic [31:0]         rdata;
    logic [32*NREGS-1:0] cfg_regs, sts_regs;
    logic [NREGS-1:0]    cfg_wr;
    logic [7:0]          irq_src = '0;

    axil_regbank #(
        .AXIL_AW(8), .NUM_REGS(NREGS), .PULSE_MASK(32'h0000_0001),
        .RO_MASK(32'h0000_0004), .IRQ_W(8), .IRQ_STAT_IDX(30), .IRQ_EN_IDX(31)
    ) dut (
        .aclk(aclk), .arest(arest),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready),
        .cfg_regs(cfg_regs), .cfg_wr(cfg_wr), .sts_regs(sts_regs),
        .irq_src(irq_src), .irq(irq)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[15];
    exp_t bq[$];
    exp_t rq[$];
    int   n_vec = 0, n_err = 0;
    int   c0 = 0, c2 = 0, c16 = 0, c18 = 0, c19 = 0, cpulse = 0;

    always @(negedge aclk) begin
        if (cfg_wr[0])  c0++;
        if (cfg_wr[2])  c2++;
        if (cfg_wr[16]) c16++;
        if (cfg_wr[18]) c18++;
        if (cfg_wr[19]) c19++;
        if (cfg_regs[31:0] != 32'd0) cpulse++;
    end

    initial begin
        sts_regs = {NREGS{32'hA5A5_0000}};
        sts_regs[32*2 +: 32] = 32'hCAFE_F00D;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timeout waiting for DUT, got none expected handshake", nm);
    endtask

    task automatic drive_aw(input logic [7:0] a);
        int n = 0;
        @(negedge aclk);
        awaddr  = a;
        awvalid = 1'b1;
        while (!awready && n < TMO) begin @(negedge aclk); n++; end
        if (!awready) timeout("awready");
        @(posedge aclk); #1 awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge aclk);
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        while (!wready && n < TMO) begin @(negedge aclk); n++; end
        if (!wready) timeout("wready");
        @(posedge aclk); #1 wvalid = 1'b0;
    endtask

    task automatic wait_b(input string nm);
        exp_t e;
        int   n = 0;
        while (!bvalid && n < TMO) begin @(negedge aclk); n++; end
        if (!bvalid) timeout(nm);
        else begin
            e = bq.pop_front();
            chk(nm, 64'(bresp), 64'(e.resp));
        end
        @(posedge aclk); #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] r);
        exp_t e;
        e.resp = r;
        e.data = 32'd0;
        bq.push_back(e);
        fork
            drive_aw(a);
            drive_w(d, s);
        join
        wait_b("bresp");
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        int   n = 0;
        e.resp = r;
        e.data = d;
        rq.push_back(e);
        @(negedge aclk);
        araddr  = a;
        arvalid = 1'b1;
        while (!arready && n < TMO) begin @(negedge aclk); n++; end
        if (!arready) timeout("arready");
        @(posedge aclk); #1 arvalid = 1'b0;
        if (!rvalid) timeout("rvalid");
        else begin
            e = rq.pop_front();
            chk("rdata", 64'(rdata), 64'(e.data));
            chk("rresp", 64'(rresp), 64'(e.resp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rdy_seen;
        int   bv_seen;

        vecs[0]  = '{1, 8'h40, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{0, 8'h40, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1, 8'h14, 32'h1234_5678, 4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1, 8'h14, 32'hAABB_CCDD, 4'h3, 2'b00, 32'h0};
        vecs[4]  = '{0, 8'h14, 32'h0,         4'h0, 2'b00, 32'h1234_CCDD};
        vecs[5]  = '{1, 8'hA0, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0};
        vecs[6]  = '{0, 8'hA0, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[7]  = '{0, 8'h20, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[8]  = '{1, 8'h08, 32'h1111_1111, 4'hF, 2'b00, 32'h0};
        vecs[9]  = '{0, 8'h08, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
        vecs[10] = '{1, 8'h7C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0};
        vecs[11] = '{0, 8'h7C, 32'h0,         4'h0, 2'b00, 32'h0000_00FF};
        vecs[12] = '{1, 8'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0};
        vecs[13] = '{0, 8'h00, 32'h0,         4'h0, 2'b00, 32'h0};
        vecs[14] = '{0, 8'hFC, 32'h0,         4'h0, 2'b10, 32'h0};

        // Reset: everything low while held, ready signals rise after release.
        #2 arest = 1'b1;
        #1 chk("reset_outputs", 64'({awready, wready, arready, bvalid, rvalid, irq,
                                     |cfg_wr, |cfg_regs, bresp, rresp, |rdata}), 64'd0);
        repeat (3) @(negedge aclk);
        arest = 1'b0;
        @(posedge aclk); #1;
        chk("ready_after_reset", 64'({awready, wready, arready}), 64'b111);

        c0 = 0; c2 = 0; c16 = 0; cpulse = 0;
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
            else            rd(vecs[i].addr, vecs[i].rdata, vecs[i].resp);
        end
        repeat (2) @(negedge aclk);
        chk("cfg_wr16_cycles", 64'(c16), 64'd1);
        chk("cfg_wr_ro_none", 64'(c2), 64'd0);
        chk("cfg_wr0_cycles", 64'(c0), 64'd1);
        chk("pulse_cycles", 64'(cpulse), 64'd1);

        // W leads AW by three cycles; strobes 0101 on a zero register.
        bq.push_back('{2'b00, 32'h0});
        c18 = 0;
        drive_w(32'h1122_3344, 4'b0101);
        repeat (3) @(negedge aclk);
        chk("no_commit_w_only", 64'({bvalid, c18 != 0}), 64'd0);
        drive_aw(8'h48);
        wait_b("bresp_w_first");
        repeat (2) @(negedge aclk);
        chk("commit_once_w_first", 64'(c18), 64'd1);
        rd(8'h48, 32'h0022_0044, 2'b00);

        // AW leads W by three cycles.
        bq.push_back('{2'b00, 32'h0});
        c19 = 0;
        drive_aw(8'h4C);
        repeat (3) @(negedge aclk);
        chk("no_commit_aw_only", 64'({bvalid, c19 != 0}), 64'd0);
        drive_w(32'h1122_3344, 4'b0101);
        wait_b("bresp_aw_first");
        repeat (2) @(negedge aclk);
        chk("commit_once_aw_first", 64'(c19), 64'd1);
        rd(8'h4C, 32'h0022_0044, 2'b00);

        // Interrupt set, set-wins-over-clear, then clear.
        wr(8'h7C, 32'h0000_0001, 4'hF, 2'b00);
        @(negedge aclk) irq_src = 8'h01;
        @(negedge aclk) irq_src = 8'h00;
        chk("irq_status_set", 64'(cfg_regs[32*30 +: 32]), 64'h1);
        chk("irq_not_yet", 64'(irq), 64'd0);
        @(negedge aclk);
        chk("irq_asserted", 64'(irq), 64'd1);
        irq_src = 8'h01;
        wr(8'h78, 32'h0000_0001, 4'hF, 2'b00);
        rd(8'h78, 32'h0000_0001, 2'b00);
        @(negedge aclk) irq_src = 8'h00;
        wr(8'h78, 32'h0000_0001, 4'hF, 2'b00);
        rd(8'h78, 32'h0000_0000, 2'b00);
        @(negedge aclk);
        chk("irq_cleared", 64'(irq), 64'd0);

        // Backpressure on B, then reset with a response pending.
        bready = 1'b0;
        fork
            drive_aw(8'h50);
            drive_w(32'h5555_AAAA, 4'hF);
        join
        begin
            int n = 0;
            while (!bvalid && n < TMO) begin @(negedge aclk); n++; end
        end
        rdy_seen = 0;
        repeat (5) begin
            @(negedge aclk);
            if (awready || wready) rdy_seen++;
        end
        chk("bp_ready_low", 64'(rdy_seen), 64'd0);
        chk("bp_bvalid_held", 64'(bvalid), 64'd1);
        arest = 1'b1;
        #1 chk("midrst_outputs", 64'({awready, wready, arready, bvalid, rvalid, irq,
                                       |cfg_wr, |cfg_regs, bresp, rresp, |rdata}), 64'd0);
        @(negedge aclk);
        arest  = 1'b0;
        bready = 1'b1;
        @(posedge aclk); #1;
        chk("ready_after_midrst", 64'({awready, wready, arready}), 64'b111);
        bv_seen = 0;
        repeat (5) begin
            @(negedge aclk);
            if (bvalid) bv_seen++;
        end
        chk("no_stale_bvalid", 64'(bv_seen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axil_regbank.md
# axil_regbank

Parametrised AXI4-Lite slave register bank for the HOG accelerator control plane. It replaces fixed-map control registers with a generic bank of `NUM_REGS` 32-bit registers, and it has the following features:
- independent AW/W acceptance;
- byte-strobe writes;
- per-register pulse (self-clearing) and read-only status modes;
- SLVERR on unmapped addresses;
- a write-1-to-clear interrupt status/enable pair that drives one level interrupt.

It sits between the processor's AXI-Lite interconnect and the HOG datapath/DMA configuration inputs.

## Interface
- `AXIL_AW`, 8: address width. Must be ≥ clog2(`NUM_REGS`)+2.
- `NUM_REGS`, 32: number of 32-bit registers. Register index = addr[`AXIL_AW`-1:2]; addr[1:0] is ignored.
- `PULSE_MASK`, 0x0000_0001: bit i=1 makes register i a pulse register.
- `RO_MASK`, 0x0000_0000: bit i=1 makes register i read-only; its read data comes from the `sts_regs` slice i.
- `IRQ_W`, 8: number of interrupt sources (1..32).
- `IRQ_STAT_IDX`, 30: index of the W1C interrupt status register.
- `IRQ_EN_IDX`, 31: index of the interrupt enable register.
- Ports:
  - `aclk` in 1: the single clock.
  - `arest` in 1: asynchronous, active-high reset.
  - `s_axil_awaddr` in `AXIL_AW`; `s_axil_awprot` in 3 (ignored); `s_axil_awvalid` in 1; `s_axil_awready` out 1.
  - `s_axil_wdata` in 32; `s_axil_wstrb` in 4; `s_axil_wvalid` in 1; `s_axil_wready` out 1.
  - `s_axil_bresp` out 2; `s_axil_bvalid` out 1; `s_axil_bready` in 1.
  - `s_axil_araddr` in `AXIL_AW`; `s_axil_arprot` in 3 (ignored); `s_axil_arvalid` in 1; `s_axil_arready` out 1.
  - `s_axil_rdata` out 32; `s_axil_rresp` out 2; `s_axil_rvalid` out 1; `s_axil_rready` in 1.
  - `cfg_regs` out 32*`NUM_REGS`: flat register contents; register i occupies bits [32i+31:32i].
  - `cfg_wr` out `NUM_REGS`: one-cycle strobe on register i, high in the cycle after a committed write to i.
  - `sts_regs` in 32*`NUM_REGS`: status inputs. Only the slices flagged in `RO_MASK` are used.
  - `irq_src` in `IRQ_W`: level-high interrupt sources, sampled every cycle.
  - `irq` out 1: registered interrupt, equal to |(status & enable).

## Operation
- **Reset.** While `arest` is high, every register, holding buffer and output is 0, including all ready/valid signals, `cfg_wr`, `irq`, `bresp` and `rresp`. On the first edge after `arest` falls, `awready`, `wready` and `arready` rise to 1.
- **AW/W buffers.**
  - Each channel has a one-entry holding buffer.
  - `awready` = !aw_full & !bvalid; `wready` = !w_full & !bvalid. Both are registered and updated on the edge.
  - AW and W may arrive in either order, in the same cycle or apart.
- **Write commit.**
  - Commit happens on the edge after both buffers are full.
  - On that edge: buffers clear, `bvalid` goes to 1, `bresp` is set, and the target register is updated.
- **Byte writes.** Only byte lanes whose `wstrb` bit is 1 are written.
- **Write response codes.**
  - Index ≥ `NUM_REGS`: `bresp`=2'b10 (SLVERR) and no state changes.
  - Write to an RO register: ignored, `bresp`=2'b00, no `cfg_wr` strobe.
- **Pulse registers.** A written value is visible on `cfg_regs` for exactly one cycle (the cycle after commit), then returns to 0.
- **Interrupt status register.**
  - Bit k is set on any cycle where `irq_src`[k]=1.
  - Bit k is cleared by a committed write with data bit k=1 in an enabled byte lane.
  - Set wins over clear in the same cycle.
  - Bits ≥ `IRQ_W` read as 0.
- **Interrupt enable register.** Plain read/write register; bits ≥ `IRQ_W` read as 0.
- **Write response handshake.** `bvalid` holds until `bready`=1. While `bvalid`=1, no new AW/W is accepted.
- **Read.**
  - `arready` = !rvalid.
  - On the accept edge, `rdata`, `rresp` and `rvalid` are registered.
  - `rdata` is the `sts_regs` slice for RO indices, otherwise the stored value.
  - Out-of-range index: `rdata`=0, `rresp`=2'b10.
  - `rvalid` holds, with data stable, until `rready`=1. Reads have no side effects.
- **Read/write ordering.** The read and write paths are independent. If a read is accepted on the same edge as a write commit to the same register, the read returns the pre-commit value.

## Timing
- **Write, AW and W together.** If AW and W handshake on edge N, the register and `bvalid` update on edge N+1, and `cfg_wr` is high during cycle N+1.
- **Back-to-back writes.** When `bready` is held high, the write throughput is one transaction every 3 cycles.
- **Read.**
  - Handshake on edge N gives `rvalid` from edge N.
  - With `rready` held high, `rvalid` falls at edge N+1 and `arready` returns at edge N+1.
  - Read throughput: one transaction every 2 cycles.
- **Interrupt latency.** `irq_src` high sampled at edge N sets status at edge N; `irq` follows at edge N+1.
- **Reset mid-transaction.** Asserting `arest` mid-transaction drops any buffered AW/W and any pending B/R immediately (asynchronously). After release, no response is issued for the dropped transaction.

## Test plan
- **Single write.** Write 0xDEAD_BEEF, `wstrb`=4'hF, to addr 0x40 (idx 16), then read it back. Required: `bresp`=0, `cfg_wr`[16] high for 1 cycle, `rdata`=0xDEAD_BEEF.
- **AW/W ordering and strobes.** Send W three cycles before AW, then AW three cycles before W; use `wstrb`=4'b0101 with data 0x1122_3344 on a register holding 0. Required: each write commits exactly once, and the readback is 0x0022_0044.
- **Pulse register.** Write 0x1 to idx 0 (`PULSE_MASK` bit 0). Required: `cfg_regs`[31:0]=1 for exactly one cycle, then 0.
- **Error and RO accesses.**
  - Write and read index 40 with `NUM_REGS`=32. Required: SLVERR on both, `rdata`=0, no register changes.
  - Write to an RO index. Required: OKAY, and the readback equals `sts_regs`.
- **Interrupt set/clear.**
  - Set enable=0x01 and pulse `irq_src`[0]. Required: status bit 0 set, `irq`=1 one cycle after the pulse.
  - Write 0x01 to `IRQ_STAT_IDX` with `irq_src`[0] held high. Required: status stays 1.
  - Release the source and repeat the write. Required: status=0 and `irq`=0.
- **Backpressure and reset.**
  - Hold `bready`=0 for 5 cycles. Required: `awready`/`wready` stay 0.
  - Assert `arest` while `bvalid`=1. Required: all outputs 0 at once; after release, ready signals return and no stale `bvalid` appears.
